// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with per-register in-flight writer scoreboard
module regfile_scoreboard #(
  parameter int PENDING_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rj_index,
  input  logic [4:0]  rk_index,
  output logic [31:0] rj_data,
  output logic [31:0] rk_data,
  output logic        rj_ready,
  output logic        rk_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd_index,
  output logic        issue_ready,
  input  logic        writeback_valid,
  input  logic [4:0]  rd_index,
  input  logic [31:0] rd_wb,
  input  logic        flush
);

  localparam logic [PENDING_W-1:0] PEND_ZERO = '0;
  localparam logic [PENDING_W-1:0] PEND_ONE  = PENDING_W'(1);
  localparam logic [PENDING_W-1:0] PEND_MAX  = '1;

  // r0 has neither storage nor a counter; it is handled by index checks.
  logic [31:0]          regs [1:31];
  logic [PENDING_W-1:0] pend [1:31];

  logic [31:0]          rj_arr, rk_arr;
  logic [PENDING_W-1:0] rj_pend, rk_pend, iss_pend;
  logic                 wb_hit_j, wb_hit_k, wb_hit_iss, issue_acc;

  // Look up array contents and counters for both read ports and the issue port.
  always_comb begin
    rj_arr   = '0;
    rk_arr   = '0;
    rj_pend  = '0;
    rk_pend  = '0;
    iss_pend = '0;
    for (int i = 1; i < 32; i++) begin
      if (rj_index == 5'(i)) begin
        rj_arr  = regs[i];
        rj_pend = pend[i];
      end
      if (rk_index == 5'(i)) begin
        rk_arr  = regs[i];
        rk_pend = pend[i];
      end
      if (issue_rd_index == 5'(i)) begin
        iss_pend = pend[i];
      end
    end
  end

  assign wb_hit_j   = writeback_valid && (rd_index == rj_index);
  assign wb_hit_k   = writeback_valid && (rd_index == rk_index);
  assign wb_hit_iss = writeback_valid && (rd_index == issue_rd_index);

  // Same-cycle writeback bypasses the array so decode sees the result immediately.
  assign rj_data = (rj_index == 5'd0) ? 32'd0 : (wb_hit_j ? rd_wb : rj_arr);
  assign rk_data = (rk_index == 5'd0) ? 32'd0 : (wb_hit_k ? rd_wb : rk_arr);

  // A single pending writer retiring this cycle makes the value final now.
  assign rj_ready = (rj_index == 5'd0) || (rj_pend == PEND_ZERO) ||
                    ((rj_pend == PEND_ONE) && wb_hit_j);
  assign rk_ready = (rk_index == 5'd0) || (rk_pend == PEND_ZERO) ||
                    ((rk_pend == PEND_ONE) && wb_hit_k);

  // A saturated counter can still accept an issue if a writer retires in the same cycle.
  assign issue_ready = (issue_rd_index == 5'd0) || (iss_pend != PEND_MAX) || wb_hit_iss;
  assign issue_acc   = issue_valid && issue_ready && (issue_rd_index != 5'd0);

  // Register array write; r0 writebacks are dropped.
  always_ff @(posedge clk) begin
    for (int i = 1; i < 32; i++) begin
      if (rst) begin
        regs[i] <= '0;
      end else if (writeback_valid && (rd_index == 5'(i))) begin
        regs[i] <= rd_wb;
      end
    end
  end

  // Pending counter update: issue increments, writeback decrements (floored), flush clears.
  always_ff @(posedge clk) begin
    for (int i = 1; i < 32; i++) begin
      if (rst || flush) begin
        pend[i] <= '0;
      end else begin
        if (issue_acc && (issue_rd_index == 5'(i)) &&
            !(writeback_valid && (rd_index == 5'(i)))) begin
          pend[i] <= pend[i] + PEND_ONE;
        end else if (writeback_valid && (rd_index == 5'(i)) &&
                     !(issue_acc && (issue_rd_index == 5'(i))) &&
                     (pend[i] != PEND_ZERO)) begin
          pend[i] <= pend[i] - PEND_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and randomized check against a behavioural model
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [4:0]  rj_index, rk_index;
  logic [31:0] rj_data, rk_data;
  logic        rj_ready, rk_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd_index;
  logic        issue_ready;
  logic        writeback_valid;
  logic [4:0]  rd_index;
  logic [31:0] rd_wb;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain values and writer counts per register.
  logic [31:0] mreg [32];
  int          mp   [32];
  bit          mvalid = 0;
  localparam int MAXP = 3;

  regfile_scoreboard #(.PENDING_W(2)) dut (
    .clk(clk), .rst(rst),
    .rj_index(rj_index), .rk_index(rk_index),
    .rj_data(rj_data), .rk_data(rk_data),
    .rj_ready(rj_ready), .rk_ready(rk_ready),
    .issue_valid(issue_valid), .issue_rd_index(issue_rd_index),
    .issue_ready(issue_ready),
    .writeback_valid(writeback_valid), .rd_index(rd_index), .rd_wb(rd_wb),
    .flush(flush)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_data(input int idx);
    if (idx == 0) return 32'd0;
    if (writeback_valid && int'(rd_index) == idx) return rd_wb;
    return mreg[idx];
  endfunction

  function automatic logic m_ready(input int idx);
    if (idx == 0) return 1'b1;
    if (mp[idx] == 0) return 1'b1;
    return (mp[idx] == 1) && writeback_valid && (int'(rd_index) == idx);
  endfunction

  function automatic logic m_issue_ready();
    int idx = int'(issue_rd_index);
    if (idx == 0) return 1'b1;
    if (mp[idx] < MAXP) return 1'b1;
    return writeback_valid && (int'(rd_index) == idx);
  endfunction

  // Compare all outputs against the model at the falling edge.
  task automatic sample();
    @(negedge clk);
    if (mvalid) begin
      chk("rj_data",     rj_data,     m_data(int'(rj_index)));
      chk("rk_data",     rk_data,     m_data(int'(rk_index)));
      chk("rj_ready",    32'(rj_ready),    32'(m_ready(int'(rj_index))));
      chk("rk_ready",    32'(rk_ready),    32'(m_ready(int'(rk_index))));
      chk("issue_ready", 32'(issue_ready), 32'(m_issue_ready()));
    end
  endtask

  // Apply this cycle's inputs to the model, then cross the rising edge.
  task automatic advance();
    int  ii = int'(issue_rd_index);
    int  ri = int'(rd_index);
    bit  inc = issue_valid && m_issue_ready() && ii != 0;
    bit  wb  = writeback_valid && ri != 0;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mreg[i] = 0; mp[i] = 0; end
      mvalid = 1;
    end else begin
      if (wb) mreg[ri] = rd_wb;
      if (flush) begin
        for (int i = 0; i < 32; i++) mp[i] = 0;
      end else if (!(inc && wb && ii == ri)) begin
        if (inc) mp[ii] = mp[ii] + 1;
        if (wb && mp[ri] > 0) mp[ri] = mp[ri] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; issue_valid = 0; issue_rd_index = 0;
    writeback_valid = 0; rd_index = 0; rd_wb = 0; rj_index = 0; rk_index = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    advance();
    rst = 0;
    advance();

    // Reset state
    idle(); sample();
    chk("rst_rj_data", rj_data, 32'd0);
    chk("rst_rj_ready", 32'(rj_ready), 32'd1);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    advance();

    // Writeback bypass and array read
    idle(); writeback_valid = 1; rd_index = 5; rd_wb = 32'h1234_5678; rj_index = 5; sample();
    chk("bypass_r5", rj_data, 32'h1234_5678);
    advance();
    idle(); rj_index = 5; sample();
    chk("array_r5", rj_data, 32'h1234_5678);
    advance();

    // RAW hazard on r7
    idle(); issue_valid = 1; issue_rd_index = 7; sample(); advance();
    idle(); rj_index = 7; sample();
    chk("r7_busy", 32'(rj_ready), 32'd0);
    advance();
    idle(); rj_index = 7; sample(); advance();
    idle(); rj_index = 7; writeback_valid = 1; rd_index = 7; rd_wb = 32'hA5; sample();
    chk("r7_ready_wb", 32'(rj_ready), 32'd1);
    chk("r7_data_wb", rj_data, 32'hA5);
    advance();

    // Counter saturation on r9
    for (int k = 0; k < 3; k++) begin
      idle(); issue_valid = 1; issue_rd_index = 9; sample(); advance();
    end
    idle(); issue_valid = 1; issue_rd_index = 9; sample();
    chk("r9_full", 32'(issue_ready), 32'd0);
    advance();
    idle(); issue_valid = 1; issue_rd_index = 9; writeback_valid = 1; rd_index = 9; rd_wb = 32'h99;
    sample();
    chk("r9_full_wb", 32'(issue_ready), 32'd1);
    advance();
    idle(); issue_rd_index = 9; sample();
    chk("r9_still_full", 32'(issue_ready), 32'd0);
    advance();

    // r0 is inert
    idle(); writeback_valid = 1; rd_index = 0; rd_wb = 32'hFFFF_FFFF;
    issue_valid = 1; issue_rd_index = 0; sample();
    chk("r0_data", rj_data, 32'd0);
    chk("r0_ready", 32'(rk_ready), 32'd1);
    chk("r0_issue_ready", 32'(issue_ready), 32'd1);
    advance();
    idle(); rk_index = 9; sample();
    chk("r9_unchanged", 32'(rk_ready), 32'd0);
    advance();

    // Flush with concurrent writeback
    idle(); issue_valid = 1; issue_rd_index = 3; sample(); advance();
    idle(); issue_valid = 1; issue_rd_index = 3; sample(); advance();
    idle(); flush = 1; writeback_valid = 1; rd_index = 3; rd_wb = 32'h77; sample(); advance();
    idle(); rj_index = 3; rk_index = 9; sample();
    chk("flush_r3_ready", 32'(rj_ready), 32'd1);
    chk("flush_r3_data", rj_data, 32'h77);
    chk("flush_r9_ready", 32'(rk_ready), 32'd1);
    advance();

    // Writeback with no pending writer, then reset with nonzero counters
    idle(); writeback_valid = 1; rd_index = 4; rd_wb = 32'hBEEF; sample(); advance();
    idle(); rj_index = 4; issue_valid = 1; issue_rd_index = 4; sample();
    chk("r4_data", rj_data, 32'hBEEF);
    advance();
    idle(); rj_index = 4; sample();
    chk("r4_floor", 32'(rj_ready), 32'd0);
    advance();
    idle(); rst = 1; issue_valid = 1; issue_rd_index = 6; sample(); advance();
    idle(); rj_index = 4; rk_index = 5; sample();
    chk("rst_r4_data", rj_data, 32'd0);
    chk("rst_r4_ready", 32'(rj_ready), 32'd1);
    chk("rst_r5_data", rk_data, 32'd0);
    advance();

    // Randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst             = ($urandom_range(0, 199) == 0);
      flush           = ($urandom_range(0, 39) == 0);
      issue_valid     = $urandom_range(0, 1);
      issue_rd_index  = 5'($urandom_range(0, 7));
      writeback_valid = $urandom_range(0, 1);
      rd_index        = 5'($urandom_range(0, 7));
      rd_wb           = $urandom;
      rj_index        = 5'($urandom_range(0, 7));
      rk_index        = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
